// File: rtl/serial_word_feeder_if.sv
// serial_word_feeder_if
// Handshake and serial-stream bundle for serial_word_feeder.
//   in_valid   : producer has a word on load_data
//   in_ready   : feeder can accept a word this cycle
//   load_data  : parallel word, WIDTH bits
//   ser_out    : serial bit to the detector's din
//   ser_valid  : ser_out carries a live data (or parity) bit
//   word_done  : pulse on the last serial bit of a word
//   busy       : a word is being shifted
// Modports: master = word producer / stream observer, slave = the feeder.
interface serial_word_feeder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output in_valid,
        output load_data,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  word_done,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  load_data,
        output in_ready,
        output ser_out,
        output ser_valid,
        output word_done,
        output busy
    );
endinterface

// File: rtl/serial_word_feeder.sv
// serial_word_feeder
// Parallel-to-serial stage feeding the serial sequence detector. Words are
// accepted over a valid/ready handshake and shifted out one bit per clock;
// back-to-back words stream with no idle gap.
// Ports:
//   clk : rising-edge clock
//   res : synchronous active-low reset
//   bus : serial_word_feeder_if.slave (in_valid, in_ready, load_data,
//         ser_out, ser_valid, word_done, busy)
// Parameters: WIDTH (2..32), MSB_FIRST (1 = bit WIDTH-1 first).
// Optional feature macro: SERIAL_PARITY_EN appends an even-parity bit
// after every word (WIDTH+1 clocks per word).
// All outputs are registered except in_ready.
module serial_word_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                 clk,
    input logic                 res,
    serial_word_feeder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_done_q, word_done_d;
    logic             busy_q, busy_d;
    logic             in_ready;
    logic             accept;
`ifdef SERIAL_PARITY_EN
    logic             par_q, par_d;
`endif

    // in_ready is the only combinational output: the feeder can take a new
    // word when idle or on the final cycle of the current word.
    always_comb begin
        in_ready = 1'b0;
        if (res) begin
            if (state_q == IDLE) begin
                in_ready = 1'b1;
            end
`ifdef SERIAL_PARITY_EN
            if (state_q == PARITY) begin
                in_ready = 1'b1;
            end
`else
            if (state_q == SHIFT && cnt_q == LAST) begin
                in_ready = 1'b1;
            end
`endif
        end
        accept = bus.in_valid && in_ready;
    end

    // Next-state logic. Outputs are computed from the next state so that the
    // registered outputs describe the bit being presented in the next cycle.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shift_d = bus.load_data;
                    cnt_d   = '0;
`ifdef SERIAL_PARITY_EN
                    par_d   = ^bus.load_data;
`endif
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
`ifdef SERIAL_PARITY_EN
                    state_d = PARITY;
                    cnt_d   = '0;
`else
                    if (accept) begin
                        shift_d = bus.load_data;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                        shift_d = '0;
                        cnt_d   = '0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (MSB_FIRST) begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    end else begin
                        shift_d = {1'b0, shift_q[WIDTH-1:1]};
                    end
                end
            end
`ifdef SERIAL_PARITY_EN
            PARITY: begin
                if (accept) begin
                    state_d = SHIFT;
                    shift_d = bus.load_data;
                    cnt_d   = '0;
                    par_d   = ^bus.load_data;
                end else begin
                    state_d = IDLE;
                    shift_d = '0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        word_done_d = 1'b0;
        busy_d      = 1'b0;
        if (state_d == SHIFT) begin
            ser_out_d   = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
            ser_valid_d = 1'b1;
            busy_d      = 1'b1;
`ifndef SERIAL_PARITY_EN
            word_done_d = (cnt_d == LAST);
`endif
        end
`ifdef SERIAL_PARITY_EN
        if (state_d == PARITY) begin
            ser_out_d   = par_d;
            ser_valid_d = 1'b1;
            busy_d      = 1'b1;
            word_done_d = 1'b1;
        end
`endif
    end

    // State and output registers; reset wins over any handshake activity.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
            busy_q      <= busy_d;
`ifdef SERIAL_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.word_done = word_done_q;
    assign bus.busy      = busy_q;
endmodule
